gcd_driver: RTL and testbench
=============================

GCD_DRIVER -- requirements
Module: gcd_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of operand-pair FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 63, meaning the maximum number of cycles to wait for done after go.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  the operand pair on in_x/in_y is offered.
REQ-006 in_ready  out  1  the FIFO can accept a pair; equals !full.
REQ-007 in_x, in_y  in  5 each  operands, unsigned.
REQ-008 gcd_x, gcd_y  out  5 each  operands to the GCD engine; stable while gcd_go=1.
REQ-009 gcd_go  out  1  level request to the GCD engine.
REQ-010 gcd_done  in  1  engine completion; sampled only while gcd_go=1.
REQ-011 gcd_result  in  5  engine result; valid in the cycle gcd_done=1.
REQ-012 res_valid  out  1  the result triple is presented.
REQ-013 res_ready  in  1  the consumer accepts the result.
REQ-014 res_x, res_y, res_gcd  out  5 each  the operands and their GCD.
REQ-015 res_err  out  1  the result was produced by timeout; res_gcd=0.

Function
REQ-016 Push occurs on in_valid && in_ready; a push while full is impossible (in_ready=0) and in_valid is ignored.
REQ-017 FIFO SHALL be first-in first-out, with wrap-around pointers and a count of width clog2(DEPTH)+1.
REQ-018 FSM states: IDLE, BUSY, RESP.
REQ-019 IDLE: if the FIFO is non-empty, pop the head, latch x/y into gcd_x/gcd_y and the result registers.
REQ-020 IDLE pop with x!=0 and y!=0 -> BUSY, gcd_go=1 from the next cycle.
REQ-021 IDLE pop with x==0 or y==0 -> RESP directly; res_gcd = x|y (gcd(0,y)=y, gcd(0,0)=0); gcd_go never asserted.
REQ-022 BUSY: gcd_go=1 and the wait counter increments each cycle.
REQ-023 BUSY, gcd_done=1 -> capture gcd_result into res_gcd, res_err=0, gcd_go=0 next cycle, -> RESP.
REQ-024 BUSY, counter reaches TIMEOUT without done -> res_gcd=0, res_err=1, gcd_go=0, -> RESP.
REQ-025 Simultaneous done and timeout in the same cycle: done wins (res_err=0).
REQ-026 RESP: res_valid=1; outputs held stable until res_ready=1, then -> IDLE with res_valid=0 the next cycle.
REQ-027 gcd_go SHALL be low for at least one cycle between engine transactions (guaranteed by RESP/IDLE).
REQ-028 Minimum latency from pop to res_valid: non-zero operands 2 + engine cycles; zero-operand bypass 1 cycle.
REQ-029 Pushes SHALL continue in every FSM state; a push and a pop in the same cycle leave the count unchanged.
REQ-030 gcd_done while gcd_go=0 SHALL be ignored.

Reset
REQ-031 rst SHALL empty the FIFO and drive state=IDLE, gcd_go=0, res_valid=0, res_err=0, gcd_x=gcd_y=0, res_x=res_y=res_gcd=0, counter=0, in_ready=1.
REQ-032 rst asserted mid-BUSY SHALL drop gcd_go the next cycle; the in-flight and queued pairs are discarded.
REQ-033 rst has priority over every other input in the same cycle.

Structure
REQ-034 A shared package gcd_pkg SHALL hold OPW=5, the FSM state enumeration and the default TIMEOUT.
REQ-035 The FIFO SHALL be the sub-module gcd_pair_fifo (10-bit data, DEPTH parameter, push/pop/full/empty/count).
REQ-036 Target size is 150-300 lines of RTL; no latches; single clock domain.

Verification
REQ-037 Push (18,10); the engine model returns done after 5 cycles with result 2 -> gcd_go high for 6 cycles, then res_valid, res_x=18, res_y=10, res_gcd=2, res_err=0.
REQ-038 Push (0,12) -> gcd_go never high; res_gcd=12 one cycle after the pop; push (0,0) -> res_gcd=0.
REQ-039 Engine never signals done -> after 63 BUSY cycles res_valid=1, res_err=1, res_gcd=0, gcd_go=0.
REQ-040 Hold res_ready=0 and push 5 pairs -> in_ready=0 after 4 are queued beyond the active pair; release res_ready -> results emerge in push order.
REQ-041 Assert rst for 1 cycle during BUSY -> gcd_go=0 next cycle, res_valid=0, in_ready=1, queued pairs lost.
REQ-042 Pulse gcd_done while in IDLE -> no state change and no res_valid.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD driver: operand width, default engine
// timeout and the controller state encoding.
package gcd_pkg;

  localparam int OPW             = 5;
  localparam int TIMEOUT_DEFAULT = 63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gcd_driver_if.sv
// Bundle of the driver's three handshakes: operand input, engine request and
// result output. The master view is the driver itself, slave is its environment.
interface gcd_driver_if;
  import gcd_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_x;
  logic [OPW-1:0] in_y;

  logic [OPW-1:0] gcd_x;
  logic [OPW-1:0] gcd_y;
  logic           gcd_go;
  logic           gcd_done;
  logic [OPW-1:0] gcd_result;

  logic           res_valid;
  logic           res_ready;
  logic [OPW-1:0] res_x;
  logic [OPW-1:0] res_y;
  logic [OPW-1:0] res_gcd;
  logic           res_err;

  modport master (
    input  in_valid, in_x, in_y, gcd_done, gcd_result, res_ready,
    output in_ready, gcd_x, gcd_y, gcd_go, res_valid, res_x, res_y, res_gcd, res_err
  );

  modport slave (
    output in_valid, in_x, in_y, gcd_done, gcd_result, res_ready,
    input  in_ready, gcd_x, gcd_y, gcd_go, res_valid, res_x, res_y, res_gcd, res_err
  );

endinterface

// File: rtl/gcd_pair_fifo.sv
// Power-of-two FIFO for operand pairs; pointers wrap naturally and the
// occupancy count is one bit wider so full and empty are distinguishable.
module gcd_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          data_i,
  output logic [DW-1:0]          data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          pushEn, popEn;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushEn  = push_i && !full_o;
  assign popEn   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + AW'(1);
      if (popEn)  rdPtr_q <= rdPtr_q + AW'(1);
      if (pushEn && !popEn)      count_q <= count_q + (AW+1)'(1);
      else if (popEn && !pushEn) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/gcd_driver.sv
// GCD driver: queues operand pairs, runs one engine transaction at a time,
// bypasses the engine when an operand is zero, and times out a silent engine.
module gcd_driver
  import gcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  gcd_driver_if.master bus
);
  localparam int            CNTW      = $clog2(DEPTH) + 1;
  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [OPW-1:0] gcdX_q, gcdX_d, gcdY_q, gcdY_d;
  logic [OPW-1:0] resX_q, resX_d, resY_q, resY_d, resGcd_q, resGcd_d;
  logic           resErr_q, resErr_d;
  logic [TW-1:0]  waitCnt_q, waitCnt_d;

  logic             fifoPop, fifoFull, fifoEmpty;
  logic [2*OPW-1:0] fifoHead;
  logic [CNTW-1:0]  fifoCount;
  logic [OPW-1:0]   headX, headY;

  gcd_pair_fifo #(
    .DEPTH (DEPTH),
    .DW    (2*OPW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .pop_i   (fifoPop),
    .data_i  ({bus.in_x, bus.in_y}),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign headX = fifoHead[2*OPW-1:OPW];
  assign headY = fifoHead[OPW-1:0];

  always_comb begin
    state_d   = state_q;
    gcdX_d    = gcdX_q;
    gcdY_d    = gcdY_q;
    resX_d    = resX_q;
    resY_d    = resY_q;
    resGcd_d  = resGcd_q;
    resErr_d  = resErr_q;
    waitCnt_d = waitCnt_q;
    fifoPop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          gcdX_d    = headX;
          gcdY_d    = headY;
          resX_d    = headX;
          resY_d    = headY;
          resErr_d  = 1'b0;
          waitCnt_d = '0;
          // A zero operand makes the GCD the other operand, so skip the engine.
          if (headX != '0 && headY != '0) begin
            resGcd_d = '0;
            state_d  = BUSY;
          end else begin
            resGcd_d = headX | headY;
            state_d  = RESP;
          end
        end
      end
      BUSY: begin
        waitCnt_d = waitCnt_q + TW'(1);
        if (bus.gcd_done) begin
          resGcd_d = bus.gcd_result;
          resErr_d = 1'b0;
          state_d  = RESP;
        end else if (waitCnt_q == LAST_WAIT) begin
          resGcd_d = '0;
          resErr_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gcdX_q    <= '0;
      gcdY_q    <= '0;
      resX_q    <= '0;
      resY_q    <= '0;
      resGcd_q  <= '0;
      resErr_q  <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gcdX_q    <= gcdX_d;
      gcdY_q    <= gcdY_d;
      resX_q    <= resX_d;
      resY_q    <= resY_d;
      resGcd_q  <= resGcd_d;
      resErr_q  <= resErr_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign bus.in_ready  = !fifoFull;
  assign bus.gcd_x     = gcdX_q;
  assign bus.gcd_y     = gcdY_q;
  assign bus.gcd_go    = (state_q == BUSY);
  assign bus.res_valid = (state_q == RESP);
  assign bus.res_x     = resX_q;
  assign bus.res_y     = resY_q;
  assign bus.res_gcd   = resGcd_q;
  assign bus.res_err   = resErr_q;

  a_countBound: assert property (@(posedge clk) disable iff (rst)
    fifoCount <= CNTW'(DEPTH));

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver with a behavioural GCD engine whose
// completion delay can be set per scenario or suppressed entirely.
module tb_gcd_driver;
  import gcd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_driver_if bus();

  gcd_driver #(
    .DEPTH   (4),
    .TIMEOUT (63)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int goCnt     = 0;
  int doneAfter = 5;
  bit engineOn  = 1'b0;
  bit forceDone = 1'b0;

  function automatic logic [4:0] refGcd(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] x, y, t;
    x = a;
    y = b;
    while (y != 5'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine raises done once gcd_go has been high for doneAfter full cycles.
  always @(posedge clk) begin
    if (!bus.gcd_go) goCnt <= 0;
    else             goCnt <= goCnt + 1;
  end
  assign bus.gcd_done   = (bus.gcd_go && engineOn && goCnt == doneAfter) || forceDone;
  assign bus.gcd_result = refGcd(bus.gcd_x, bus.gcd_y);

  task automatic pushPair(input logic [4:0] x, input logic [4:0] y);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic acceptResult();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic waitResult(input int budget, output int goCycles, output bit ok);
    goCycles = 0;
    ok       = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
      if (bus.gcd_go) goCycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.gcd_go !== 1'b0 ||
        bus.res_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got ready=%b valid=%b go=%b err=%b want 1 0 0 0",
               bus.in_ready, bus.res_valid, bus.gcd_go, bus.res_err);
    end
    checks++;
    if (bus.gcd_x !== 5'd0 || bus.gcd_y !== 5'd0 || bus.res_x !== 5'd0 ||
        bus.res_y !== 5'd0 || bus.res_gcd !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_data got gx=%0d gy=%0d rx=%0d ry=%0d rg=%0d want all 0",
               bus.gcd_x, bus.gcd_y, bus.res_x, bus.res_y, bus.res_gcd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one engine transaction and checks go duration plus the result triple.
  task automatic runEngineCase(input string name, input logic [4:0] x, input logic [4:0] y,
                               input int expGo, input logic [4:0] expGcd, input logic expErr);
    int  goCycles;
    bit  ok;
    pushPair(x, y);
    waitResult(200, goCycles, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s_no_result got res_valid=0 want 1 within 200 cycles", name);
    end
    checks++;
    if (goCycles != expGo) begin
      failures++;
      $display("[TB] FAIL %s_go_cycles got=%0d want=%0d", name, goCycles, expGo);
    end
    checks++;
    if (bus.res_x !== x || bus.res_y !== y || bus.res_gcd !== expGcd ||
        bus.res_err !== expErr || bus.gcd_go !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_result got x=%0d y=%0d gcd=%0d err=%b go=%b want %0d %0d %0d %b 0",
               name, bus.res_x, bus.res_y, bus.res_gcd, bus.res_err, bus.gcd_go,
               x, y, expGcd, expErr);
    end
    acceptResult();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_release got res_valid=%b want 0", name, bus.res_valid);
    end
  endtask

  task automatic test_basic();
    engineOn  = 1'b1;
    doneAfter = 5;
    runEngineCase("basic", 5'd18, 5'd10, 6, 5'd2, 1'b0);
  endtask

  task automatic test_bypass();
    bit goSeen;
    pushPair(5'd0, 5'd12);
    goSeen = bus.gcd_go;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bypass_pop_cycle got res_valid=%b want 0", bus.res_valid);
    end
    @(negedge clk);
    goSeen |= bus.gcd_go;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_gcd !== 5'd12 || bus.res_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bypass_0_12 got valid=%b gcd=%0d err=%b want 1 12 0",
               bus.res_valid, bus.res_gcd, bus.res_err);
    end
    acceptResult();
    pushPair(5'd0, 5'd0);
    goSeen |= bus.gcd_go;
    @(negedge clk);
    goSeen |= bus.gcd_go;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_gcd !== 5'd0 || bus.res_x !== 5'd0) begin
      failures++;
      $display("[TB] FAIL bypass_0_0 got valid=%b gcd=%0d x=%0d want 1 0 0",
               bus.res_valid, bus.res_gcd, bus.res_x);
    end
    checks++;
    if (goSeen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bypass_go got gcd_go seen=%b want 0", goSeen);
    end
    acceptResult();
  endtask

  task automatic test_timeout();
    engineOn = 1'b0;
    runEngineCase("timeout", 5'd9, 5'd6, 63, 5'd0, 1'b1);
  endtask

  task automatic test_done_timeout_tie();
    engineOn  = 1'b1;
    doneAfter = 62;
    runEngineCase("tie", 5'd9, 5'd6, 63, 5'd3, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] expX [5] = '{5'd12, 5'd0, 5'd15, 5'd7, 5'd21};
    logic [4:0] expY [5] = '{5'd8,  5'd5, 5'd10, 5'd0, 5'd14};
    logic [4:0] expG [5] = '{5'd4,  5'd5, 5'd5,  5'd7, 5'd7};
    int goCycles;
    bit ok;
    bit extra;
    engineOn      = 1'b1;
    doneAfter     = 2;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) pushPair(expX[i], expY[i]);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_full got in_ready=%b want 0", bus.in_ready);
    end
    pushPair(5'd1, 5'd1);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitResult(50, goCycles, ok);
      checks++;
      if (!ok || bus.res_x !== expX[i] || bus.res_y !== expY[i] || bus.res_gcd !== expG[i]) begin
        failures++;
        $display("[TB] FAIL b2b_order_%0d got ok=%b x=%0d y=%0d gcd=%0d want 1 %0d %0d %0d",
                 i, ok, bus.res_x, bus.res_y, bus.res_gcd, expX[i], expY[i], expG[i]);
      end
      @(negedge clk);
    end
    extra = 1'b0;
    repeat (10) begin
      extra |= bus.res_valid;
      @(negedge clk);
    end
    checks++;
    if (extra !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_drop_when_full got extra=%b ready=%b want 0 1",
               extra, bus.in_ready);
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    bit seen;
    engineOn = 1'b0;
    pushPair(5'd9, 5'd6);
    pushPair(5'd3, 5'd3);
    pushPair(5'd4, 5'd0);
    checks++;
    if (bus.gcd_go !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstbusy_pre got gcd_go=%b want 1", bus.gcd_go);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.gcd_go !== 1'b0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.gcd_x !== 5'd0) begin
      failures++;
      $display("[TB] FAIL rstbusy_after got go=%b valid=%b ready=%b gx=%0d want 0 0 1 0",
               bus.gcd_go, bus.res_valid, bus.in_ready, bus.gcd_x);
    end
    seen = 1'b0;
    repeat (20) begin
      seen |= bus.res_valid | bus.gcd_go;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstbusy_queue_lost got activity=%b want 0", seen);
    end
  endtask

  task automatic test_spurious_done();
    bit seen;
    forceDone = 1'b1;
    @(negedge clk);
    forceDone = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen |= bus.res_valid | bus.gcd_go;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0 || bus.res_gcd !== 5'd0 || bus.res_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_done got activity=%b gcd=%0d err=%b want 0 0 0",
               seen, bus.res_gcd, bus.res_err);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_timeout();
    test_done_timeout_tie();
    test_back_to_back();
    test_reset_busy();
    test_spurious_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
